// File: rtl/i2c_target.sv
// I2C target at a fixed 7-bit address that gives an external master byte access to a register bank.
// A pointer byte comes first; data bytes then follow with pointer auto-increment, for both writes and reads.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    localparam int        PW       = $clog2(NUM_REGS)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t        state_r;
    logic [1:0]    scl_sync_r;
    logic [1:0]    sda_sync_r;
    logic          scl_d_r;
    logic          sda_d_r;
    logic [3:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [PW-1:0] ptr_r;
    logic          rw_r;

    logic          scl_s;
    logic          sda_s;
    logic          rise_s;
    logic          fall_s;
    logic          start_s;
    logic          stop_s;
    logic [PW-1:0] ptr_inc_s;
    logic [7:0]    rd_byte_s;

    assign scl_s     = scl_sync_r[1];
    assign sda_s     = sda_sync_r[1];
    assign rise_s    = scl_s & ~scl_d_r;
    assign fall_s    = ~scl_s & scl_d_r;
    assign start_s   = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s    = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign ptr_inc_s = (ptr_r == PW'(NUM_REGS - 1)) ? '0 : ptr_r + PW'(1);
    assign rd_byte_s = regs_flat[{ptr_r, 3'b000} +: 8];

    // Bus-line synchronizers; they reset to the idle-high level so release cannot fake an edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // Protocol FSM: bits are sampled on rise; SDA is only ever changed on fall.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r   <= IDLE;
            sda_oe    <= 1'b0;
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= '0;
            rw_r      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_s) begin
                state_r   <= ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_s) begin
                state_r <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    ADDR: begin
                        if (rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (fall_s && bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[7:1] == I2C_ADDR) begin
                                rw_r    <= shift_r[0];
                                sda_oe  <= 1'b1;
                                state_r <= ADDR_ACK;
                            end else begin
                                state_r <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (rw_r) begin
                                shift_r <= rd_byte_s;
                                sda_oe  <= ~rd_byte_s[7];
                                state_r <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state_r <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (fall_s && bit_cnt_r == 4'd8) begin
                            ptr_r     <= shift_r[PW-1:0];
                            sda_oe    <= 1'b1;
                            bit_cnt_r <= 4'd0;
                            state_r   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (fall_s) begin
                            sda_oe    <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (fall_s && bit_cnt_r == 4'd8) begin
                            regs_flat[{ptr_r, 3'b000} +: 8] <= shift_r;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr_r;
                            wr_data   <= shift_r;
                            ptr_r     <= ptr_inc_s;
                            sda_oe    <= 1'b1;
                            bit_cnt_r <= 4'd0;
                            state_r   <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state_r <= RDATA_ACK;
                            end else begin
                                sda_oe  <= ~shift_r[6];
                                shift_r <= {shift_r[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // A fall is only seen here after an ACK; a NACK leaves on the rise.
                        if (rise_s) begin
                            if (!sda_s) begin
                                ptr_r <= ptr_inc_s;
                            end else begin
                                state_r <= WAIT_STOP;
                            end
                        end else if (fall_s) begin
                            shift_r   <= rd_byte_s;
                            sda_oe    <= ~rd_byte_s[7];
                            bit_cnt_r <= 4'd0;
                            state_r   <= RDATA;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        sda_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 100;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic         sda_bus;
    logic         sda_oe;
    logic [127:0] regs_flat;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         busy;

    int           total = 0;
    int           bad = 0;
    logic [127:0] exp_regs = 128'h0;
    logic [3:0]   st_addr[$];
    logic [7:0]   st_data[$];
    logic         oe_seen = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target dut (
        .aclk      (aclk),
        .areset    (areset),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (!areset && wr_strobe) begin
            st_addr.push_back(wr_addr);
            st_data.push_back(wr_data);
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        #Q scl_m = 1'b1;
        #Q s = sda_bus;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(~ack, s);
    endtask

    task automatic test_reset();
        #25;
        total++;
        if (sda_oe !== 1'b0 || busy !== 1'b0 || wr_strobe !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: oe=%b busy=%b strobe=%b, want 0 0 0", sda_oe, busy, wr_strobe);
        end
        total++;
        if (regs_flat !== 128'h0 || wr_addr !== 4'h0 || wr_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: regs=%h addr=%h data=%h, want zeros", regs_flat, wr_addr, wr_data);
        end
        areset = 1'b0;
        #50;
    endtask

    task automatic test_write();
        logic [3:0] acks;
        st_addr.delete(); st_data.delete();
        i2c_start();
        write_byte(8'hA0, acks[3]);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL write_busy: busy=%b, want 1", busy);
        end
        write_byte(8'h03, acks[2]);
        write_byte(8'h5A, acks[1]);
        write_byte(8'hC3, acks[0]);
        i2c_stop();
        exp_regs[8*3 +: 8] = 8'h5A;
        exp_regs[8*4 +: 8] = 8'hC3;
        total++;
        if (acks !== 4'b1111) begin
            bad++;
            $display("FAIL write_acks: got %b, want 1111", acks);
        end
        total++;
        if (regs_flat !== exp_regs) begin
            bad++;
            $display("FAIL write_regs: got %h, want %h", regs_flat, exp_regs);
        end
        total++;
        if (st_addr.size() != 2) begin
            bad++;
            $display("FAIL write_strobes: got %0d pulses, want 2", st_addr.size());
        end else if (st_addr[0] !== 4'd3 || st_data[0] !== 8'h5A || st_addr[1] !== 4'd4 || st_data[1] !== 8'hC3) begin
            bad++;
            $display("FAIL write_strobes: got (%0d,%h)(%0d,%h), want (3,5a)(4,c3)", st_addr[0], st_data[0], st_addr[1], st_data[1]);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL write_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_read();
        logic [2:0] acks;
        logic [7:0] d0, d1, d2;
        i2c_start();
        write_byte(8'hA0, acks[2]);
        write_byte(8'h03, acks[1]);
        i2c_rstart();
        write_byte(8'hA1, acks[0]);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        i2c_stop();
        total++;
        if (acks !== 3'b111) begin
            bad++;
            $display("FAIL read_acks: got %b, want 111", acks);
        end
        total++;
        if (d0 !== 8'h5A || d1 !== 8'hC3) begin
            bad++;
            $display("FAIL read_data: got %h %h, want 5a c3", d0, d1);
        end
        // Pointer should still be 4 because the NACK does not advance it.
        i2c_start();
        write_byte(8'hA1, acks[0]);
        read_byte(1'b0, d2);
        i2c_stop();
        total++;
        if (acks[0] !== 1'b1 || d2 !== 8'hC3) begin
            bad++;
            $display("FAIL read_ptr_kept: ack=%b data=%h, want 1 c3", acks[0], d2);
        end
    endtask

    task automatic test_mismatch();
        logic [2:0] acks;
        st_addr.delete(); st_data.delete();
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'hFF, acks[0]);
        i2c_stop();
        total++;
        if (acks !== 3'b000 || oe_seen !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_ack: acks=%b oe_seen=%b, want 000 0", acks, oe_seen);
        end
        total++;
        if (st_addr.size() != 0 || regs_flat !== exp_regs) begin
            bad++;
            $display("FAIL mismatch_regs: strobes=%0d regs=%h, want 0 %h", st_addr.size(), regs_flat, exp_regs);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] acks;
        st_addr.delete(); st_data.delete();
        i2c_start();
        write_byte(8'hA0, acks[6]);
        write_byte(8'h0F, acks[5]);
        write_byte(8'h11, acks[4]);
        write_byte(8'h22, acks[3]);
        i2c_stop();
        exp_regs[8*15 +: 8] = 8'h11;
        exp_regs[8*0 +: 8]  = 8'h22;
        total++;
        if (regs_flat !== exp_regs) begin
            bad++;
            $display("FAIL wrap_regs: got %h, want %h", regs_flat, exp_regs);
        end
        total++;
        if (st_addr.size() != 2) begin
            bad++;
            $display("FAIL wrap_strobes: got %0d pulses, want 2", st_addr.size());
        end else if (st_addr[0] !== 4'd15 || st_data[0] !== 8'h11 || st_addr[1] !== 4'd0 || st_data[1] !== 8'h22) begin
            bad++;
            $display("FAIL wrap_strobes: got (%0d,%h)(%0d,%h), want (15,11)(0,22)", st_addr[0], st_data[0], st_addr[1], st_data[1]);
        end
        i2c_start();
        write_byte(8'hA0, acks[2]);
        write_byte(8'h1F, acks[1]);
        write_byte(8'h33, acks[0]);
        i2c_stop();
        exp_regs[8*15 +: 8] = 8'h33;
        total++;
        if (acks !== 7'h7F || regs_flat !== exp_regs) begin
            bad++;
            $display("FAIL wrap_ptr_mask: acks=%b regs=%h, want 1111111 %h", acks, regs_flat, exp_regs);
        end
    endtask

    task automatic test_abort();
        logic [4:0] acks;
        logic       s;
        st_addr.delete(); st_data.delete();
        i2c_start();
        write_byte(8'hA0, acks[4]);
        write_byte(8'h05, acks[3]);
        bit_cycle(1'b1, s);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        i2c_stop();
        total++;
        if (busy !== 1'b0 || st_addr.size() != 0 || regs_flat !== exp_regs) begin
            bad++;
            $display("FAIL abort_state: busy=%b strobes=%0d regs=%h, want 0 0 %h", busy, st_addr.size(), regs_flat, exp_regs);
        end
        i2c_start();
        write_byte(8'hA0, acks[2]);
        write_byte(8'h06, acks[1]);
        write_byte(8'h77, acks[0]);
        i2c_stop();
        exp_regs[8*6 +: 8] = 8'h77;
        total++;
        if (acks !== 5'b11111 || regs_flat !== exp_regs || st_addr.size() != 1) begin
            bad++;
            $display("FAIL abort_after: acks=%b strobes=%0d regs=%h, want 11111 1 %h", acks, st_addr.size(), regs_flat, exp_regs);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] acks;
        i2c_start();
        write_byte(8'hA0, acks[2]);
        write_byte(8'h03, acks[1]);
        i2c_rstart();
        write_byte(8'hA1, acks[0]);
        total++;
        if (acks !== 3'b111 || sda_oe !== 1'b1) begin
            bad++;
            $display("FAIL rst_read_drive: acks=%b oe=%b, want 111 1", acks, sda_oe);
        end
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        total++;
        if (sda_oe !== 1'b0 || regs_flat !== 128'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: oe=%b busy=%b regs=%h, want 0 0 0", sda_oe, busy, regs_flat);
        end
        #30 areset = 1'b0;
        exp_regs = 128'h0;
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) for the SoC. It answers a fixed 7-bit address and gives an external I2C master byte access to a 16 x 8-bit register bank.
- It is the responder counterpart to the AXI-lite I2C initiator. The team uses it as an on-chip loopback target for that master and as a device model.
- A byte pointer is written first, then data bytes are written or read with pointer auto-increment.
- The register bank is exposed in parallel to local logic.

Parameters:
- I2C_ADDR, 7'h50, target address compared against the first byte after START.
- NUM_REGS, 16, register bank depth in bytes; the pointer is log2(NUM_REGS) bits and wraps.

Ports:
- aclk  input  1  system clock; must be at least 8x the SCL frequency.
- areset  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL line as seen from the pad (asynchronous).
- sda_in  input  1  SDA line as seen from the pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- regs_flat  output  8*NUM_REGS  register bank; reg[i] = bits [8i+7:8i].
- wr_strobe  output  1  one-cycle pulse for each data byte written by the master.
- wr_addr  output  log2(NUM_REGS)  register index for wr_strobe.
- wr_data  output  8  byte written, valid with wr_strobe.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate): sda_oe=0, regs=0, pointer=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE.
- Reset asserted mid-transfer releases SDA in the same instant.
- Input sampling: scl_in and sda_in each pass through a 2-FF synchronizer, giving scl_s and sda_s; one delayed copy of each is kept.
- Edge definitions:
  - rise = scl_s 0->1; fall = scl_s 1->0.
  - START = sda_s 1->0 while scl_s and its delayed copy are both 1.
  - STOP = sda_s 0->1 under the same condition.
- Priority: STOP/START detection overrides all bit processing in the same cycle.
- Data bits are sampled on rise, MSB first. The target changes sda_oe only on fall, so SDA is never moved while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state (including repeated START): go to ADDR, clear the bit counter, sda_oe=0.
- STOP from any state: go to IDLE, sda_oe=0. The pointer is retained.
- ADDR:
  - Shift 8 bits.
  - On the fall after bit 8: if addr[7:1]==I2C_ADDR, set sda_oe=1 and go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with no ACK.
- ADDR_ACK: on the next fall, set sda_oe=0.
  - R/W=0: go to PTR.
  - R/W=1: load shift register = reg[pointer], drive its MSB (sda_oe = ~bit7), go to RDATA.
- PTR: shift 8 bits; on fall after bit 8, pointer = byte mod NUM_REGS, sda_oe=1, go to PTR_ACK. The upper pointer bits are ignored.
- PTR_ACK: on fall, sda_oe=0, go to WDATA.
- WDATA:
  - After 8 bits, on the fall: reg[pointer]=byte and pulse wr_strobe for one aclk, with wr_addr=pointer and wr_data=byte.
  - Then pointer = pointer+1, wrapping NUM_REGS-1 -> 0; sda_oe=1; go to WDATA_ACK.
- WDATA_ACK: on fall, sda_oe=0, go to WDATA.
- RDATA:
  - On each fall, present the next bit (sda_oe = ~bit), MSB first.
  - On the fall after bit 8, sda_oe=0 (release for the master ACK) and go to RDATA_ACK.
- RDATA_ACK: sample SDA on rise.
  - 0 (ACK): pointer+1 with wrap; on the next fall load reg[pointer] and drive its MSB; go to RDATA.
  - 1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore all bits, sda_oe=0; leave only on START or STOP.
- There is no clock stretching and no general-call support. A local write path into the bank does not exist.

Test Plan:
- Write with pointer: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP.
  - Expect ACK on all 4 bytes.
  - reg[3]=0x5A, reg[4]=0xC3.
  - Two wr_strobe pulses: (3,0x5A) then (4,0xC3); busy low after STOP.
- Read via repeated START: START, 0xA0, ptr 0x03, Sr, 0xA1, read 2 bytes (ACK, then NACK), STOP.
  - SDA shows 0x5A then 0xC3.
  - Pointer=4 after the NACK, because the NACK does not increment it.
- Address mismatch: START, 0xA2, 0x00, 0xFF, STOP.
  - No ACK on any byte; sda_oe stays 0 throughout.
  - No wr_strobe; regs unchanged.
- Pointer wrap: ptr 0x0F, write 0x11, 0x22.
  - reg[15]=0x11, reg[0]=0x22.
  - Pointer byte 0x1F selects reg[15].
- Abort: STOP issued after 3 bits of a data byte.
  - Returns to IDLE; no wr_strobe; regs unchanged.
  - A following transaction works normally.
- Reset mid-read: assert areset while the target drives a 0 bit.
  - sda_oe=0 and regs_flat=0 without waiting for an aclk edge.
